lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_pkg.sv | 25 ++
 rtl/lsu_align.sv | 69 ++++++
 rtl/lsu_ctrl.sv | 126 ++++++++++++
 tb/tb_lsu_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: datapath widths, memory opcodes and FSM state encoding.
package lsu_ctrl_pkg;

  localparam int CPU_WIDTH    = 32;
  localparam int MEM_OP_WIDTH = 3;

  typedef enum logic [MEM_OP_WIDTH-1:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_LBU = 3'd3,
    MEM_LHU = 3'd4,
    MEM_SB  = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/data and misalign detection for the incoming
// request, plus lane select and extension of the returned read word.
module lsu_align
  import lsu_ctrl_pkg::*;
(
  input  logic [MEM_OP_WIDTH-1:0] req_op_i,
  input  logic [1:0]              req_off_i,
  input  logic                    req_store_i,
  input  logic [CPU_WIDTH-1:0]    req_wdata_i,
  output logic [3:0]              wstrb_o,
  output logic [CPU_WIDTH-1:0]    wdata_o,
  output logic                    misalign_o,
  input  logic [MEM_OP_WIDTH-1:0] rsp_op_i,
  input  logic [1:0]              rsp_off_i,
  input  logic [CPU_WIDTH-1:0]    rsp_word_i,
  output logic [CPU_WIDTH-1:0]    rdata_o
);

  logic [CPU_WIDTH-1:0] shifted;

  assign shifted = rsp_word_i >> {rsp_off_i, 3'b000};

  always_comb begin
    misalign_o = 1'b0;
    case (mem_op_e'(req_op_i))
      MEM_LW, MEM_SW:          misalign_o = |req_off_i;
      MEM_LH, MEM_LHU, MEM_SH: misalign_o = req_off_i[0];
      default:                 misalign_o = 1'b0;
    endcase
  end

  always_comb begin
    wstrb_o = '0;
    wdata_o = '0;
    if (req_store_i) begin
      case (mem_op_e'(req_op_i))
        MEM_SB: begin
          wstrb_o = 4'b0001 << req_off_i;
          wdata_o = {4{req_wdata_i[7:0]}};
        end
        MEM_SH: begin
          wstrb_o = 4'b0011 << req_off_i;
          wdata_o = {2{req_wdata_i[15:0]}};
        end
        MEM_SW: begin
          wstrb_o = '1;
          wdata_o = req_wdata_i;
        end
        default: begin
          wstrb_o = '0;
          wdata_o = '0;
        end
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (mem_op_e'(rsp_op_i))
      MEM_LB:  rdata_o = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LH:  rdata_o = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LW:  rdata_o = shifted;
      MEM_LBU: rdata_o = {24'b0, shifted[7:0]};
      MEM_LHU: rdata_o = {16'b0, shifted[15:0]};
      default: rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: single-outstanding bus transaction FSM that stalls the core
// until the access completes, then presents the extended load result for one cycle.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_ren,
  input  logic                    mem_wen,
  input  logic [MEM_OP_WIDTH-1:0] mem_op,
  input  logic [CPU_WIDTH-1:0]    addr,
  input  logic [CPU_WIDTH-1:0]    wdata,
  output logic                    stall,
  output logic [CPU_WIDTH-1:0]    rdata,
  output logic                    rdata_vld,
  output logic                    misalign,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [CPU_WIDTH-1:0]    bus_addr,
  output logic [3:0]              bus_wstrb,
  output logic [CPU_WIDTH-1:0]    bus_wdata,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [CPU_WIDTH-1:0]    bus_rdata
);

  lsu_state_e state_q, state_d;

  logic [MEM_OP_WIDTH-1:0] op_q;
  logic [1:0]              off_q;
  logic [CPU_WIDTH-1:0]    bus_addr_q, bus_wdata_q, rdata_q;
  logic [3:0]              bus_wstrb_q;
  logic                    bus_we_q, rdata_vld_q, misalign_q;

  logic                    req;
  logic                    req_mis;
  logic [3:0]              req_wstrb;
  logic [CPU_WIDTH-1:0]    req_wdata, load_data;

  assign req = mem_wen | mem_ren;

  lsu_align u_align (
    .req_op_i   (mem_op),
    .req_off_i  (addr[1:0]),
    .req_store_i(mem_wen),
    .req_wdata_i(wdata),
    .wstrb_o    (req_wstrb),
    .wdata_o    (req_wdata),
    .misalign_o (req_mis),
    .rsp_op_i   (op_q),
    .rsp_off_i  (off_q),
    .rsp_word_i (bus_rdata),
    .rdata_o    (load_data)
  );

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bus_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          stall   = 1'b1;
          state_d = req_mis ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        if (bus_gnt) state_d = ST_RESP;
      end
      ST_RESP: begin
        stall = 1'b1;
        if (bus_rvalid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      off_q       <= '0;
      bus_addr_q  <= '0;
      bus_we_q    <= 1'b0;
      bus_wstrb_q <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_vld_q <= 1'b0;
      misalign_q  <= 1'b0;
      if (state_q == ST_IDLE && req) begin
        if (req_mis) begin
          misalign_q <= 1'b1;
          rdata_q    <= '0;
        end else begin
          op_q        <= mem_op;
          off_q       <= addr[1:0];
          bus_addr_q  <= {addr[CPU_WIDTH-1:2], 2'b00};
          bus_we_q    <= mem_wen;
          bus_wstrb_q <= req_wstrb;
          bus_wdata_q <= req_wdata;
        end
      end
      // Stores also finish on rvalid but leave rdata untouched.
      if (state_q == ST_RESP && bus_rvalid && !bus_we_q) begin
        rdata_q     <= load_data;
        rdata_vld_q <= 1'b1;
      end
    end
  end

  assign rdata     = rdata_q;
  assign rdata_vld = rdata_vld_q;
  assign misalign  = misalign_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wstrb = bus_wstrb_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: transaction-level reference model predicts every output per cycle,
// driven by directed cases followed by randomized loads/stores with random bus timing.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren, mem_wen;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata;
  logic        stall, rdata_vld, misalign;
  logic [31:0] rdata;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  logic        exp_stall, exp_rdata_vld, exp_misalign, exp_bus_req, exp_bus_we;
  logic [31:0] exp_rdata, exp_bus_addr, exp_bus_wdata;
  logic [3:0]  exp_bus_wstrb;

  int unsigned tot = 0;
  int unsigned bad = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_op(mem_op), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_vld(rdata_vld), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",     32'(stall),     32'(exp_stall));
      chk("bus_req",   32'(bus_req),   32'(exp_bus_req));
      chk("bus_we",    32'(bus_we),    32'(exp_bus_we));
      chk("bus_addr",  bus_addr,       exp_bus_addr);
      chk("bus_wstrb", 32'(bus_wstrb), 32'(exp_bus_wstrb));
      chk("bus_wdata", bus_wdata,      exp_bus_wdata);
      chk("rdata",     rdata,          exp_rdata);
      chk("rdata_vld", 32'(rdata_vld), 32'(exp_rdata_vld));
      chk("misalign",  32'(misalign),  32'(exp_misalign));
    end
  end

  // Reference rules, written as plain arithmetic on the request.
  function automatic bit m_mis(input logic [2:0] op, input logic [31:0] a);
    if (op == MEM_LW || op == MEM_SW) return (a % 4) != 0;
    if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] v, b, h;
    v = w >> (8 * (a % 4));
    b = v & 32'hFF;
    h = v & 32'hFFFF;
    case (op)
      MEM_LB:  return (b >= 128)   ? b + 32'hFFFF_FF00 : b;
      MEM_LH:  return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      MEM_LW:  return w;
      MEM_LBU: return b;
      MEM_LHU: return h;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] op, input logic [31:0] a);
    case (op)
      MEM_SB:  return 4'(1 << (a % 4));
      MEM_SH:  return 4'(3 << (a % 4));
      MEM_SW:  return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] w);
    case (op)
      MEM_SB:  return (w & 32'hFF) * 32'h0101_0101;
      MEM_SH:  return (w & 32'hFFFF) * 32'h0001_0001;
      MEM_SW:  return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop();
    mem_ren = 1'b0;
    mem_wen = 1'b0;
    addr    = $urandom;
    wdata   = $urandom;
  endtask

  task automatic zero_exp();
    exp_stall = 0; exp_rdata_vld = 0; exp_misalign = 0; exp_bus_req = 0; exp_bus_we = 0;
    exp_rdata = 0; exp_bus_addr = 0; exp_bus_wdata = 0; exp_bus_wstrb = 0;
  endtask

  // One request: g = extra cycles before gnt, r = extra cycles before rvalid.
  task automatic do_txn(input logic ren, input logic wen, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] wd, input int g,
                        input int r, input logic [31:0] word, input bit abort);
    mem_ren = ren; mem_wen = wen; mem_op = op; addr = a; wdata = wd;
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom % 2); bus_rdata = word;
    exp_stall = 1; exp_bus_req = 0; exp_rdata_vld = 0; exp_misalign = 0;
    step();
    if (m_mis(op, a)) begin
      drop();
      bus_gnt = 0; bus_rvalid = 0;
      exp_stall = 0; exp_misalign = 1; exp_rdata = 0;
      step();
    end else begin
      exp_bus_addr  = a & ~32'h3;
      exp_bus_we    = wen;
      exp_bus_wstrb = wen ? m_strb(op, a) : 4'h0;
      exp_bus_wdata = wen ? m_wdata(op, wd) : 32'h0;
      for (int i = 0; i <= g; i++) begin
        exp_bus_req = 1; exp_stall = 1;
        bus_gnt = (i == g); bus_rvalid = 1'($urandom % 2);
        addr = $urandom; wdata = $urandom;
        step();
      end
      exp_bus_req = 0;
      if (abort) begin
        bus_gnt = 0; bus_rvalid = 0; rst = 1;
        step();
        rst = 0;
        drop();
        zero_exp();
        bus_gnt = 1; bus_rvalid = 1;
        step();
        bus_gnt = 0; bus_rvalid = 0;
        step();
        return;
      end
      for (int j = 0; j <= r; j++) begin
        exp_stall = 1;
        bus_gnt = 1'($urandom % 2); bus_rvalid = (j == r);
        step();
      end
      drop();
      bus_gnt = 1'($urandom % 2); bus_rvalid = 1'($urandom % 2);
      exp_stall = 0;
      if (!wen) begin
        exp_rdata_vld = 1;
        exp_rdata = m_load(op, a, word);
      end
      step();
    end
    exp_stall = 0; exp_rdata_vld = 0; exp_misalign = 0;
    bus_gnt = 0; bus_rvalid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic        st;

    rst = 1; mem_ren = 0; mem_wen = 0; mem_op = 0; addr = 0; wdata = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    zero_exp();
    step();
    chk_en = 1;
    step();
    rst = 0;
    step();

    // LB 0x103, immediate gnt/rvalid
    do_txn(1, 0, MEM_LB, 32'h103, 32'h0, 0, 0, 32'h80FF_FF01, 0);
    chk("lb_rdata", rdata, 32'hFFFF_FF80);

    // SH 0x202, decoder asserts both enables
    do_txn(1, 1, MEM_SH, 32'h202, 32'h1234_ABCD, 0, 0, 32'h0, 0);
    chk("sh_addr",  bus_addr, 32'h200);
    chk("sh_wstrb", 32'(bus_wstrb), 32'hC);
    chk("sh_wdata", bus_wdata, 32'hABCD_ABCD);
    chk("sh_we",    32'(bus_we), 32'h1);
    chk("sh_rdata_held", rdata, 32'hFFFF_FF80);

    // LW misaligned
    do_txn(1, 0, MEM_LW, 32'h101, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    chk("lw_mis_rdata", rdata, 32'h0);
    chk("lw_mis_addr_held", bus_addr, 32'h200);

    // LHU 0x002, gnt after 4 extra cycles, rvalid 2 more
    do_txn(1, 0, MEM_LHU, 32'h002, 32'h0, 4, 2, 32'hF00D_1234, 0);
    chk("lhu_rdata", rdata, 32'h0000_F00D);

    // SW with decoder store encoding
    do_txn(1, 1, MEM_SW, 32'h40C, 32'h5566_7788, 0, 1, 32'h0, 0);
    chk("sw_we",    32'(bus_we), 32'h1);
    chk("sw_wstrb", 32'(bus_wstrb), 32'hF);
    chk("sw_wdata", bus_wdata, 32'h5566_7788);

    // Reset while waiting for rvalid
    do_txn(1, 0, MEM_LW, 32'h300, 32'h0, 1, 0, 32'h1111_2222, 1);
    chk("rst_addr",  bus_addr, 32'h0);
    chk("rst_wstrb", 32'(bus_wstrb), 32'h0);
    chk("rst_rdata", rdata, 32'h0);

    for (int n = 0; n < 300; n++) begin
      op = 3'($urandom % 8);
      st = (op >= MEM_SB);
      a  = $urandom;
      if ($urandom % 4 != 0) begin
        if (op == MEM_LW || op == MEM_SW) a = a & ~32'h3;
        else if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) a = a & ~32'h1;
      end
      do_txn(st ? 1'($urandom % 2) : 1'b1, st, op, a, $urandom,
             int'($urandom % 5), int'($urandom % 3), $urandom, ($urandom % 40) == 0);
      repeat ($urandom % 3) begin
        bus_gnt = 1'($urandom % 2); bus_rvalid = 1'($urandom % 2);
        addr = $urandom;
        step();
      end
      bus_gnt = 0; bus_rvalid = 0;
    end

    step();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
